sprite_mem_loader: RTL and testbench

- Writer side of the sprite memory. The sprite renderers read this memory via `sprite_addr`/`sprite_data` (RGB565, 13-bit word address).
- Accepts a stream of RGB565 pixels from the CPU/loader datapath and writes them into sprite RAM starting at a commanded base address.
- Writes are gated to vertical blanking so an on-screen sprite never tears.
- Sits between the CPU I/O interface and the write port of the sprite RAM that feeds the bitgen sprite blocks.

---
 rtl/sprite_pkg.sv | 25 ++
 rtl/sprite_load_ctr.sv | 34 +++
 rtl/sprite_mem_loader.sv | 121 ++++++++++++
 tb/tb_sprite_mem_loader.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants for the sprite memory path: loader FSM encoding, RGB565 layout,
// sprite RAM geometry and VGA vertical timing.
package sprite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VB = 2'd1,
    ST_LOAD    = 2'd2,
    ST_FINISH  = 2'd3
  } load_state_t;

  localparam int RGB_R_W  = 5;
  localparam int RGB_G_W  = 6;
  localparam int RGB_B_W  = 5;
  localparam int RGB565_W = RGB_R_W + RGB_G_W + RGB_B_W;

  localparam int SPRITE_ADDR_W = 13;

  localparam logic [SPRITE_ADDR_W-1:0] DINO_BASE   = 13'd0;
  localparam logic [SPRITE_ADDR_W-1:0] CACTUS_BASE = 13'd4096;

  localparam int VGA_ACTIVE_LINES = 480;
  localparam int VGA_TOTAL_LINES  = 525;

endpackage

// File: rtl/sprite_load_ctr.sv
// Write-address / remaining-count register pair for the sprite loader, with a
// sticky flag recording that the address wrapped during the current load.
module sprite_load_ctr #(
  parameter int ADDR_W = 13
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W:0]   i_count,
  input  logic              i_step,
  output logic [ADDR_W-1:0] o_addr,
  output logic [ADDR_W:0]   o_remain,
  output logic              o_wrap_err
);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_addr     <= '0;
      o_remain   <= '0;
      o_wrap_err <= 1'b0;
    end else if (i_load) begin
      o_addr     <= i_base;
      o_remain   <= i_count;
      o_wrap_err <= 1'b0;
    end else if (i_step) begin
      o_addr   <= o_addr + 1'b1;
      o_remain <= o_remain - 1'b1;
      // stepping from the all-ones address wraps to 0
      if (&o_addr) o_wrap_err <= 1'b1;
    end
  end

endmodule

// File: rtl/sprite_mem_loader.sv
// Streams RGB565 pixels into sprite RAM, writing only during vertical blank.
// Define SPRITE_LOAD_CHECKSUM_EN to add a 16-bit running sum of written pixels.
module sprite_mem_loader
  import sprite_pkg::*;
#(
  parameter int ADDR_W       = SPRITE_ADDR_W,
  parameter int DATA_W       = RGB565_W,
  parameter int ACTIVE_LINES = VGA_ACTIVE_LINES,
  parameter int TOTAL_LINES  = VGA_TOTAL_LINES
) (
  input  logic              pix_clk,
  input  logic              reset,
  input  logic [9:0]        vcount,
  input  logic              start,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_count,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
`ifdef SPRITE_LOAD_CHECKSUM_EN
  output logic              wrap_err,
  output logic [DATA_W-1:0] checksum
`else
  output logic              wrap_err
`endif
);

  localparam logic [9:0] LP_ACTIVE = 10'(ACTIVE_LINES);
  localparam logic [9:0] LP_TOTAL  = 10'(TOTAL_LINES);

  load_state_t       r_state;
  logic              w_vblank;
  logic              w_start_ok;
  logic              w_beat;
  logic              w_remain_nz;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W:0]   w_remain;

  // out-of-range lines past the wrap are blank as well
  assign w_vblank    = (vcount >= LP_ACTIVE) || (vcount >= LP_TOTAL);
  assign w_start_ok  = start && (r_state == ST_IDLE);
  assign w_remain_nz = |w_remain;
  assign pix_ready   = (r_state == ST_LOAD) && w_vblank && w_remain_nz;
  assign w_beat      = pix_valid && pix_ready;

  sprite_load_ctr #(.ADDR_W(ADDR_W)) u_ctr (
    .i_clk      (pix_clk),
    .i_rst      (reset),
    .i_load     (w_start_ok),
    .i_base     (cmd_base),
    .i_count    (cmd_count),
    .i_step     (w_beat),
    .o_addr     (w_addr),
    .o_remain   (w_remain),
    .o_wrap_err (wrap_err)
  );

  always_ff @(posedge pix_clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= w_beat;
      done   <= 1'b0;
      if (w_beat) begin
        mem_addr  <= w_addr;
        mem_wdata <= pix_data;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (cmd_count == '0) begin
              r_state <= ST_FINISH;
              done    <= 1'b1;
            end else begin
              r_state <= ST_WAIT_VB;
              busy    <= 1'b1;
            end
          end
        end
        ST_WAIT_VB: begin
          if (w_vblank) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          // the final beat's write lands first, then the done cycle follows
          if (!w_remain_nz) begin
            r_state <= ST_FINISH;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else if (!w_vblank) begin
            r_state <= ST_WAIT_VB;
          end
        end
        ST_FINISH: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPRITE_LOAD_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;

  always_ff @(posedge pix_clk or posedge reset) begin
    if (reset)           r_sum <= '0;
    else if (w_start_ok) r_sum <= '0;
    else if (w_beat)     r_sum <= r_sum + pix_data;
  end

  assign checksum = r_sum;
`endif

endmodule

// File: tb/tb_sprite_mem_loader.sv
// Scoreboard bench for sprite_mem_loader: expected RAM writes are queued at each
// handshake beat and retired by a monitor that watches the write port.
module tb_sprite_mem_loader;
  import sprite_pkg::*;

  logic        pix_clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  vcount = '0;
  logic        start = 1'b0;
  logic [12:0] cmd_base = '0;
  logic [13:0] cmd_count = '0;
  logic        pix_valid = 1'b0;
  logic [15:0] pix_data = '0;
  logic        pix_ready, mem_we, busy, done, wrap_err;
  logic [12:0] mem_addr;
  logic [15:0] mem_wdata;
`ifdef SPRITE_LOAD_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  sprite_mem_loader dut (
    .pix_clk   (pix_clk),
    .reset     (reset),
    .vcount    (vcount),
    .start     (start),
    .cmd_base  (cmd_base),
    .cmd_count (cmd_count),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
`ifdef SPRITE_LOAD_CHECKSUM_EN
    .wrap_err  (wrap_err),
    .checksum  (checksum)
`else
    .wrap_err  (wrap_err)
`endif
  );

  always #5 pix_clk = ~pix_clk;

  typedef struct packed {
    logic [12:0] a;
    logic [15:0] d;
  } wr_t;

  int          errors = 0;
  int          checks = 0;
  wr_t         exp_q[$];
  logic [15:0] pix_q[$];
  logic [12:0] m_addr = '0;
  logic        prev_beat = 1'b0;
  wr_t         mon_e;

  // every write must follow a beat by exactly one cycle and match the queue head
  always @(negedge pix_clk) begin
    if (reset) begin
      prev_beat = 1'b0;
    end else begin
      checks++;
      if (mem_we !== prev_beat) begin
        errors++;
        $display("FAIL we_latency: mem_we=%b expected %b at %0t", mem_we, prev_beat, $time);
      end
      if (mem_we === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: addr=%0d data=%h at %0t", mem_addr, mem_wdata, $time);
        end else begin
          mon_e = exp_q.pop_front();
          if (mem_addr !== mon_e.a || mem_wdata !== mon_e.d) begin
            errors++;
            $display("FAIL write: got addr=%0d data=%h expected addr=%0d data=%h",
                     mem_addr, mem_wdata, mon_e.a, mon_e.d);
          end
        end
      end
      prev_beat = pix_valid & pix_ready;
    end
  end

  task automatic do_start(input logic [12:0] b, input logic [13:0] c);
    cmd_base  = b;
    cmd_count = c;
    start     = 1'b1;
    @(posedge pix_clk); #1;
    start  = 1'b0;
    m_addr = b;
  endtask

  task automatic feed(input int n);
    wr_t w;
    for (int i = 0; i < n; i++) begin
      pix_data  = pix_q.pop_front();
      pix_valid = 1'b1;
      for (int t = 0; ; t++) begin
        @(negedge pix_clk);
        if (pix_ready === 1'b1) break;
        if (t > 200) begin
          checks++; errors++;
          $display("FAIL feed_timeout: pix_ready=%b expected 1 within 200 cycles", pix_ready);
          pix_valid = 1'b0;
          return;
        end
      end
      w.a = m_addr;
      w.d = pix_data;
      exp_q.push_back(w);
      m_addr = m_addr + 13'd1;
      @(posedge pix_clk); #1;
    end
    pix_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge pix_clk);
    #1;
    checks++;
    if ({busy, done, mem_we, wrap_err, pix_ready, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b we=%b wrap=%b rdy=%b addr=%0d data=%h expected all 0",
               busy, done, mem_we, wrap_err, pix_ready, mem_addr, mem_wdata);
    end
    reset = 1'b0;
    @(posedge pix_clk); #1;
  endtask

  task automatic test_basic;
    vcount = 10'd490;
    pix_q = '{16'hF800, 16'h07E0, 16'h001F, 16'hF81F};
    do_start(CACTUS_BASE, 14'd4);
    checks++;
    if (busy !== 1'b1 || pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: busy=%b rdy=%b expected 1/0", busy, pix_ready);
    end
    feed(4);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_last_write: done=%b busy=%b expected 0/1", done, busy);
    end
    @(posedge pix_clk); #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%b busy=%b we=%b expected 1/0/0", done, busy, mem_we);
    end
    @(posedge pix_clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_after: done=%b busy=%b pending=%0d expected 0/0/0", done, busy, exp_q.size());
    end
  endtask

  task automatic test_gating;
    int rdy = 0;
    vcount = 10'd100;
    pix_q = '{16'h1111, 16'h2222, 16'h3333};
    do_start(DINO_BASE, 14'd3);
    pix_valid = 1'b1;
    pix_data  = pix_q[0];
    repeat (20) begin
      @(negedge pix_clk);
      if (pix_ready !== 1'b0) rdy++;
    end
    checks++;
    if (rdy != 0) begin
      errors++;
      $display("FAIL gate_active: pix_ready high on %0d cycles expected 0", rdy);
    end
    @(posedge pix_clk); #1;
    vcount = 10'd480;
    feed(3);
    @(posedge pix_clk); #1;
    checks++;
    if (done !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL gate_done: done=%b pending=%0d expected 1/0", done, exp_q.size());
    end
    // load split across the frame wrap
    @(posedge pix_clk); #1;
    vcount = 10'd524;
    pix_q = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005, 16'hA006, 16'hA007, 16'hA008};
    do_start(13'd1000, 14'd8);
    feed(3);
    vcount    = 10'd0;
    pix_valid = 1'b1;
    pix_data  = pix_q[0];
    rdy = 0;
    repeat (10) begin
      @(negedge pix_clk);
      if (pix_ready !== 1'b0) rdy++;
    end
    checks++;
    if (rdy != 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL gate_split: ready cycles=%0d busy=%b expected 0/1", rdy, busy);
    end
    @(posedge pix_clk); #1;
    vcount = 10'd480;
    feed(5);
    @(posedge pix_clk); #1;
    checks++;
    if (done !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL gate_split_done: done=%b pending=%0d expected 1/0", done, exp_q.size());
    end
    @(posedge pix_clk); #1;
  endtask

  task automatic test_zero_ignore;
    vcount = 10'd490;
    do_start(13'd50, 14'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: done=%b busy=%b expected 1/0", done, busy);
    end
    @(posedge pix_clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL zero_pulse: done=%b expected 0", done);
    end
    pix_q = '{16'h0AAA, 16'h0BBB, 16'h0CCC};
    do_start(13'd100, 14'd3);
    cmd_base  = 13'd2000;
    cmd_count = 14'd5;
    start     = 1'b1;
    @(posedge pix_clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL ignore_busy: busy=%b expected 1", busy);
    end
    feed(3);
    @(posedge pix_clk); #1;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL ignore_done: done=%b expected 1", done);
    end
    cmd_base  = 13'd3000;
    cmd_count = 14'd2;
    start     = 1'b1;
    @(posedge pix_clk); #1;
    start = 1'b0;
    repeat (5) @(posedge pix_clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ignore_at_done: busy=%b done=%b pending=%0d expected 0/0/0", busy, done, exp_q.size());
    end
  endtask

  task automatic test_wrap;
    vcount = 10'd490;
    pix_q = '{16'hC001, 16'hC002, 16'hC003, 16'hC004, 16'h5555};
    do_start(13'd8190, 14'd4);
    feed(1);
    checks++;
    if (wrap_err !== 1'b0) begin
      errors++;
      $display("FAIL wrap_early: wrap_err=%b expected 0", wrap_err);
    end
    feed(1);
    checks++;
    if (wrap_err !== 1'b1) begin
      errors++;
      $display("FAIL wrap_set: wrap_err=%b expected 1", wrap_err);
    end
    feed(2);
    @(posedge pix_clk); #1;
    checks++;
    if (done !== 1'b1 || wrap_err !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_done: done=%b wrap=%b pending=%0d expected 1/1/0", done, wrap_err, exp_q.size());
    end
    @(posedge pix_clk); #1;
    do_start(13'd5, 14'd1);
    checks++;
    if (wrap_err !== 1'b0) begin
      errors++;
      $display("FAIL wrap_clear: wrap_err=%b expected 0", wrap_err);
    end
    feed(1);
    @(posedge pix_clk); #1;
    checks++;
    if (done !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_next_done: done=%b pending=%0d expected 1/0", done, exp_q.size());
    end
    @(posedge pix_clk); #1;
  endtask

  task automatic test_reset_mid_load;
    int rdy = 0;
    vcount = 10'd490;
    pix_q.delete();
    for (int i = 0; i < 10; i++) pix_q.push_back(16'hD000 + 16'(i));
    do_start(13'd200, 14'd10);
    feed(2);
    @(negedge pix_clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, mem_we, wrap_err, pix_ready, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b we=%b wrap=%b rdy=%b addr=%0d data=%h expected all 0",
               busy, done, mem_we, wrap_err, pix_ready, mem_addr, mem_wdata);
    end
    exp_q.delete();
    pix_valid = 1'b1;
    pix_data  = pix_q[0];
    repeat (3) @(posedge pix_clk);
    #1;
    reset = 1'b0;
    repeat (5) begin
      @(negedge pix_clk);
      if (pix_ready !== 1'b0) rdy++;
    end
    @(posedge pix_clk); #1;
    pix_valid = 1'b0;
    checks++;
    if (rdy != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: ready cycles=%0d busy=%b expected 0/0", rdy, busy);
    end
    pix_q = '{16'hE001, 16'hE002};
    do_start(13'd300, 14'd2);
    feed(2);
    @(posedge pix_clk); #1;
    checks++;
    if (done !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_reload: done=%b pending=%0d expected 1/0", done, exp_q.size());
    end
    @(posedge pix_clk); #1;
  endtask

`ifdef SPRITE_LOAD_CHECKSUM_EN
  task automatic test_checksum;
    vcount = 10'd490;
    pix_q = '{16'hFFFF, 16'h0002};
    do_start(13'd10, 14'd2);
    feed(2);
    @(posedge pix_clk); #1;
    checks++;
    if (done !== 1'b1 || checksum !== 16'h0001) begin
      errors++;
      $display("FAIL checksum: done=%b checksum=%h expected 1/0001", done, checksum);
    end
    @(posedge pix_clk); #1;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_gating();
    test_zero_ignore();
    test_wrap();
    test_reset_mid_load();
`ifdef SPRITE_LOAD_CHECKSUM_EN
    test_checksum();
`endif
    repeat (3) @(posedge pix_clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending writes=%0d expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
